// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with valid/ready command and response ports
// Ports: PCLK, PRESETn (async active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command in;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout response out;
//        PADDR/PSELx/PENABLE/PWRITE/PWDATA bus out; PREADY/PRDATA/PSLVERR bus in.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic tmo;
  // the counter still holds TIMEOUT-1 on the edge that ends the TIMEOUT-th low-PREADY cycle
  assign tmo = (TIMEOUT != 0) && !PREADY && (cnt == CNT_W'(TIMEOUT - 1));
  // bus and handshake outputs decode straight from the state so reset drops them immediately
  assign cmd_ready = state == IDLE;
  assign PSELx     = state == SETUP || state == ACCESS;
  assign PENABLE   = state == ACCESS;
  assign rsp_valid = state == RESP;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (PREADY || tmo) ? RESP : ACCESS;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      cnt         <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      // saturating so a disabled timeout never wraps
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !PREADY && cnt != '1) cnt <= cnt + 1'b1;
      // PREADY has priority over the timeout terminal count
      if (state == ACCESS && PREADY) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (state == ACCESS && tmo) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized transaction bench with a cycle-level expectation model for apb_master
module tb_apb_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TMO = 4;
  logic PCLK = 1'b0;
  logic PRESETn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DW-1:0] PWDATA, PRDATA;
  always #5 PCLK = ~PCLK;
  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );
  // expected outputs for the current cycle
  logic exp_crdy, exp_psel, exp_pen, exp_rv, exp_pwrite, exp_err, exp_tmo;
  logic [AW-1:0] exp_paddr;
  logic [DW-1:0] exp_pwdata, exp_rdata;
  int n_vec = 0, n_bad = 0;
  // per-transaction observations of the DUT, used by the literal checks
  int cyc = 0, t_acc = 0, lat = 0, n_psel = 0, n_pen = 0;
  logic got = 1'b0;
  logic [DW-1:0] cap_rdata, cap_pwdata;
  logic [AW-1:0] cap_paddr;
  logic cap_err, cap_tmo;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, e, cyc);
    end
  endtask
  task automatic exp_reset();
    exp_crdy = 1; exp_psel = 0; exp_pen = 0; exp_rv = 0;
    exp_paddr = '0; exp_pwrite = 0; exp_pwdata = '0;
    exp_rdata = '0; exp_err = 0; exp_tmo = 0;
  endtask
  task automatic step();
    @(negedge PCLK);
    chk("cmd_ready", cmd_ready, exp_crdy);
    chk("PSELx", PSELx, exp_psel);
    chk("PENABLE", PENABLE, exp_pen);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("PADDR", PADDR, exp_paddr);
    chk("PWRITE", PWRITE, exp_pwrite);
    chk("PWDATA", PWDATA, exp_pwdata);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_timeout", rsp_timeout, exp_tmo);
    if (cmd_valid && cmd_ready) begin
      t_acc = cyc; n_psel = 0; n_pen = 0; got = 0;
    end
    if (PSELx) n_psel++;
    if (PENABLE) begin
      n_pen++; cap_paddr = PADDR; cap_pwdata = PWDATA;
    end
    if (rsp_valid && !got) begin
      got = 1; lat = cyc - t_acc;
      cap_rdata = rsp_rdata; cap_err = rsp_err; cap_tmo = rsp_timeout;
    end
    cyc++;
    @(posedge PCLK);
    #1;
  endtask
  task automatic junk_bus();
    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
  endtask
  task automatic junk_cmd();
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = 8'($urandom); cmd_wdata = $urandom;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      junk_cmd(); cmd_valid = 0; junk_bus(); rsp_ready = 1'($urandom);
      step();
    end
  endtask
  // one transfer: waits = low-PREADY ACCESS cycles before PREADY, hold = rsp_ready-low cycles
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int waits,
                     input logic [DW-1:0] rd, input logic se, input int hold);
    logic [DW-1:0] p_rdata;
    logic p_err, p_tmo, done;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    junk_bus(); rsp_ready = 1'($urandom);
    exp_crdy = 1; exp_psel = 0; exp_pen = 0; exp_rv = 0;
    step();
    exp_paddr = a; exp_pwrite = w; exp_pwdata = wd; exp_crdy = 0; exp_psel = 1;
    junk_cmd(); junk_bus();
    step();
    exp_pen = 1; done = 0; p_rdata = '0; p_err = 0; p_tmo = 0;
    for (int i = 0; !done; i++) begin
      junk_cmd();
      PREADY = (i == waits);
      PRDATA = (i == waits) ? rd : $urandom;
      PSLVERR = (i == waits) ? se : 1'($urandom);
      if (i == waits) begin
        p_rdata = w ? '0 : rd; p_err = se; p_tmo = 0; done = 1;
      end else if (i + 1 == TMO) begin
        p_rdata = '0; p_err = 1; p_tmo = 1; done = 1;
      end
      step();
    end
    exp_psel = 0; exp_pen = 0; exp_rv = 1;
    exp_rdata = p_rdata; exp_err = p_err; exp_tmo = p_tmo;
    for (int j = 0; j <= hold; j++) begin
      junk_cmd(); junk_bus();
      rsp_ready = (j == hold);
      step();
    end
    exp_rv = 0; exp_crdy = 1;
    cmd_valid = 0;
  endtask
  initial begin
    PRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; PREADY = 0; PRDATA = '0; PSLVERR = 0;
    exp_reset();
    #1;
    step();
    PRESETn = 1;
    step();
    txn(1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 0, 0);
    chk("wr_psel_cycles", n_psel, 2);
    chk("wr_penable_cycles", n_pen, 1);
    chk("wr_latency", lat, 3);
    chk("wr_paddr", cap_paddr, 8'h10);
    chk("wr_pwdata", cap_pwdata, 32'hDEADBEEF);
    chk("wr_rdata", cap_rdata, 0);
    chk("wr_err", cap_err, 0);
    txn(0, 8'h22, 32'h0, 3, 32'h12345678, 0, 0);
    chk("rd3_penable_cycles", n_pen, 4);
    chk("rd3_rdata", cap_rdata, 32'h12345678);
    chk("rd3_err", cap_err, 0);
    chk("rd3_timeout", cap_tmo, 0);
    txn(0, 8'h7F, 32'h0, 0, 32'hCAFE007F, 1, 0);
    chk("slverr_err", cap_err, 1);
    chk("slverr_rdata", cap_rdata, 32'hCAFE007F);
    chk("slverr_timeout", cap_tmo, 0);
    txn(0, 8'h30, 32'h0, 20, 32'h55, 0, 0);
    chk("tmo_penable_cycles", n_pen, 4);
    chk("tmo_rdata", cap_rdata, 0);
    chk("tmo_err", cap_err, 1);
    chk("tmo_timeout", cap_tmo, 1);
    txn(0, 8'h31, 32'h0, 3, 32'hA5A5A5A5, 0, 0);
    chk("tmo_edge_penable_cycles", n_pen, 4);
    chk("tmo_edge_rdata", cap_rdata, 32'hA5A5A5A5);
    chk("tmo_edge_timeout", cap_tmo, 0);
    txn(1, 8'h40, 32'h01020304, 1, 32'h0, 0, 5);
    txn(0, 8'h41, 32'h0, 0, 32'h0BADF00D, 0, 0);
    chk("b2b_latency", lat, 3);
    chk("b2b_rdata", cap_rdata, 32'h0BADF00D);
    // reset in the middle of ACCESS
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h55; cmd_wdata = 32'h11112222;
    exp_crdy = 1;
    step();
    exp_paddr = 8'h55; exp_pwrite = 1; exp_pwdata = 32'h11112222; exp_crdy = 0; exp_psel = 1;
    cmd_valid = 0; PREADY = 0;
    step();
    exp_pen = 1; PREADY = 0;
    #1 PRESETn = 0;
    #1;
    chk("rst_async_psel", PSELx, 0);
    chk("rst_async_penable", PENABLE, 0);
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_cmd_ready", cmd_ready, 1);
    exp_reset();
    step();
    step();
    PRESETn = 1;
    step();
    txn(1, 8'h66, 32'h77778888, 0, 32'h0, 0, 0);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_pwdata", cap_pwdata, 32'h77778888);
    chk("post_rst_err", cap_err, 0);
    for (int t = 0; t < 200; t++) begin
      idle($urandom_range(0, 2));
      txn(1'($urandom), 8'($urandom), $urandom, $urandom_range(0, 6), $urandom,
          1'($urandom), $urandom_range(0, 3));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
